// File: rtl/cpu_controller.sv
// Simple RISC Machine controller: instruction register, field decode and the
// Moore control FSM that sequences the datapath one micro-op per clock.
module cpu_controller #(
    parameter logic [1:0] MNONE  = 2'b00,
    parameter logic [1:0] MREAD  = 2'b01,
    parameter logic [1:0] MWRITE = 2'b10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] mdata,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic        loadc,
    output logic        loads,
    output logic [1:0]  vsel,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        load_addr,
    output logic        addr_sel,
    output logic [1:0]  mem_cmd,
    output logic        halted
);

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B,
        S_EXEC, S_WR_RD, S_ADDR_CALC, S_LD_ADDR, S_MEM_RD, S_WB_MEM,
        S_STR_MOV, S_MEM_WR, S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        load_ir;
    logic [2:0]  nsel;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_movi, is_movr, is_mvn, is_alu, is_cmp, is_ldr, is_str, is_halt;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

    // is_alu covers the two-operand ops that read Rn: ADD, CMP, AND
    assign is_movi = (opcode == 3'b110) && (op == 2'b10);
    assign is_movr = (opcode == 3'b110) && (op == 2'b00);
    assign is_mvn  = (opcode == 3'b101) && (op == 2'b11);
    assign is_alu  = (opcode == 3'b101) && (op != 2'b11);
    assign is_cmp  = (opcode == 3'b101) && (op == 2'b01);
    assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
    assign is_str  = (opcode == 3'b100) && (op == 2'b00);
    assign is_halt = (opcode == 3'b111);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RST;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        ir_d = load_ir ? mdata : ir_q;
    end

    assign readnum  = nsel;
    assign writenum = nsel;

    always_comb begin
        state_d   = state_q;
        load_ir   = 1'b0;
        nsel      = rn;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        vsel      = 2'b00;
        shift     = 2'b00;
        ALUop     = 2'b00;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        mem_cmd   = MNONE;
        halted    = 1'b0;

        case (state_q)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
                state_d  = S_IF1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = MREAD;
                state_d  = S_IF2;
            end
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = MREAD;
                load_ir  = 1'b1;
                state_d  = S_UPD_PC;
            end
            S_UPD_PC: begin
                load_pc = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_movi)                       state_d = S_WR_IMM;
                else if (is_movr || is_mvn)        state_d = S_GET_B;
                else if (is_alu || is_ldr || is_str) state_d = S_GET_A;
                else if (is_halt)                  state_d = S_HALT;
                else                               state_d = S_IF1;
            end
            S_WR_IMM: begin
                vsel    = 2'b01;
                write   = 1'b1;
                state_d = S_IF1;
            end
            S_GET_A: begin
                loada   = 1'b1;
                state_d = (is_ldr || is_str) ? S_ADDR_CALC : S_GET_B;
            end
            S_GET_B: begin
                loadb = 1'b1;
                // GET_B is shared: STR latches the store data (Rd), ALU ops latch Rm
                if (is_str) begin
                    nsel    = rd;
                    state_d = S_STR_MOV;
                end else begin
                    nsel    = rm;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                shift = sh;
                ALUop = op;
                asel  = is_movr || is_mvn;
                if (is_cmp) begin
                    loads   = 1'b1;
                    state_d = S_IF1;
                end else begin
                    loadc   = 1'b1;
                    state_d = S_WR_RD;
                end
            end
            S_WR_RD: begin
                nsel    = rd;
                vsel    = 2'b11;
                write   = 1'b1;
                state_d = S_IF1;
            end
            S_ADDR_CALC: begin
                bsel    = 1'b1;
                loadc   = 1'b1;
                state_d = S_LD_ADDR;
            end
            S_LD_ADDR: begin
                load_addr = 1'b1;
                state_d   = is_ldr ? S_MEM_RD : S_GET_B;
            end
            S_MEM_RD: begin
                mem_cmd = MREAD;
                state_d = S_WB_MEM;
            end
            S_WB_MEM: begin
                mem_cmd = MREAD;
                nsel    = rd;
                vsel    = 2'b00;
                write   = 1'b1;
                state_d = S_IF1;
            end
            S_STR_MOV: begin
                asel    = 1'b1;
                loadc   = 1'b1;
                state_d = S_MEM_WR;
            end
            S_MEM_WR: begin
                mem_cmd = MWRITE;
                state_d = S_IF1;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_RST;
        endcase
    end

endmodule
